serial_operand_serializer_msb_first: RTL and testbench
======================================================

# serial_operand_serializer_msb_first

Parallel-to-serial transmitter that feeds operand pairs to the MSB-first serial comparator. It accepts two WIDTH-bit operands through a valid/ready handshake. It then emits them one bit per cycle, most significant bit first, on two lock-step serial lanes, together with word-framing strobes. It sits upstream of the comparator and drives the comparator's a/b inputs and per-word restart.

## Interface

- WIDTH, 8: operand width in bits; legal range ≥ 2.

- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  WIDTH  operand A, parallel.
- in_b  input  WIDTH  operand B, parallel.
- out_valid  output  1  out_a/out_b carry a live bit this cycle.
- out_a  output  1  current serial bit of A.
- out_b  output  1  current serial bit of B.
- out_first  output  1  current bit is the MSB (bit WIDTH-1) of a word; used as the comparator restart.
- out_last  output  1  current bit is the LSB (bit 0) of a word.

## Operation

- **State machine:** two states, IDLE and SHIFT. Internal registers are sh_a and sh_b (WIDTH bits each) and cnt ($clog2(WIDTH) bits).
- **IDLE:**
  - in_ready=1.
  - When in_valid&&in_ready: load sh_a=in_a, sh_b=in_b, cnt=WIDTH-1, then go to SHIFT.
- **SHIFT:**
  - out_valid=1.
  - out_a=sh_a[WIDTH-1] and out_b=sh_b[WIDTH-1].
  - out_first=(cnt==WIDTH-1) and out_last=(cnt==0).
  - Each cycle, shift sh_a and sh_b left by 1 (zero fill) and decrement cnt.
  - When cnt==0 (last bit), either go to IDLE or reload; see Configuration.
- **Idle outputs:** outside SHIFT, out_valid, out_a, out_b, out_first and out_last are all 0. Lanes are gated, never left floating with stale data.
- **Offers while busy:** in_valid while in_ready=0 is ignored. Operands are not sampled and the word in flight is not corrupted. The source must hold in_valid and its data until accepted.
- **Arithmetic:** operands are unsigned bit patterns; no sign handling. cnt never wraps: it is reloaded or the FSM leaves SHIFT at 0.
- **Reset mid-word:** reset asserted at any point takes effect immediately (asynchronous).
  - State goes to IDLE; sh_a, sh_b and cnt go to 0; all out_* go to 0.
  - The partial word is discarded, not resumed.
  - The downstream comparator shares rst.

## Timing

- **Reset values:** out_valid=0, out_a=0, out_b=0, out_first=0, out_last=0, in_ready=1. Any handshake while rst=1 is ignored.
- **Latency:** the pair is accepted at edge N. The MSB is visible in the cycle after N. The LSB is visible in cycle N+WIDTH.
- **Framing:** out_first and out_last are single-cycle pulses, exactly one of each per word. They are never high together, since WIDTH ≥ 2.
- **Output timing:** all outputs are decoded from registers only; there is no combinational path from in_* to out_*. in_ready is combinational from state/cnt only, never from in_valid.

## Configuration

- **SERIALIZER_PRELOAD_EN defined:**
  - in_ready is also 1 in SHIFT when cnt==0.
  - An accept on the last-bit cycle reloads the registers and stays in SHIFT.
  - Back-to-back words run with no bubble, at a word period of WIDTH cycles.
- **SERIALIZER_PRELOAD_EN undefined:**
  - in_ready=0 throughout SHIFT.
  - After the LSB the FSM always spends at least one cycle in IDLE.
  - The minimum word period is WIDTH+1 cycles, and out_valid drops for one cycle between words.

## Structure

- **Shared package serial_pkg:**
  - State enum typedef (IDLE, SHIFT).
  - Default-width constant SERIAL_WIDTH_DEFAULT=8.
- **Sub-module shift_reg_msb (natural, optional):** a single-lane WIDTH-bit load/shift-left register with an MSB tap, instantiated twice (lanes A and B). FSM and counter stay in the top module.

## Test plan

- **Reset:** assert rst mid-simulation -> all out_*=0 immediately; in_ready=1 one cycle after release.
- **Single word:** WIDTH=8, in_a=8'hA5, in_b=8'h3C ->
  - out_a bits: 1,0,1,0,0,1,0,1.
  - out_b bits: 0,0,1,1,1,1,0,0.
  - out_first on bit 1 and out_last on bit 8.
  - in_ready=0 for the whole word.
- **Back-to-back:** in_valid held high with pairs (8'hFF, 8'h00), then (8'h01, 8'h02) ->
  - With SERIALIZER_PRELOAD_EN: second out_first lands exactly 8 cycles after the first, and out_valid never drops.
  - Without it: the gap is 9 cycles, with one out_valid=0 cycle.
- **Offer while busy (macro off):** change in_a/in_b at bit 4 with in_valid=1 -> serial stream of the current word is unchanged; the new pair is accepted only after it.
- **Reset mid-word:** assert rst at bit 3 of 8'hF0/8'h0F -> outputs go to 0 that cycle. The next word, 8'h12/8'h34, then serializes cleanly from its MSB with out_first=1.
- **Chained with comparator, plus WIDTH=2:**
  - Chained: in_a=8'h80, in_b=8'h7F -> comparator reports a_greater_b from the first bit and holds it to out_last.
  - Separately, WIDTH=2 with in_a=2'b10, in_b=2'b01 -> first and last pulses occur on consecutive cycles.

Source files
------------

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and constants for the MSB-first serial operand
//                path (serializer and downstream comparator).
//                Contents:
//                  SERIAL_WIDTH_DEFAULT - default operand width in bits
//                  ser_state_e          - serializer FSM state encoding
//                  ser_cnt_width()      - bit-counter width for a given WIDTH
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  localparam int SERIAL_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Width of a down-counter that must hold WIDTH-1. Floors at 1 so that the
  // counter never collapses to zero bits.
  function automatic int ser_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_operand_serializer_msb_first_shift.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_msb
//  Description : Single-lane WIDTH-bit parallel-load / shift-left register
//                with its MSB exposed. Load has priority over shift. Shifting
//                fills the LSB with zero.
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset, clears the lane
//                load      - capture load_data this cycle
//                shift     - shift left by one this cycle (ignored on load)
//                load_data - parallel operand
//                msb       - current bit WIDTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_msb
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb = data_q[WIDTH-1];

endmodule : shift_reg_msb
`default_nettype wire

// File: rtl/serial_operand_serializer_msb_first.sv
`default_nettype none
// ============================================================================
//  Module      : serial_operand_serializer_msb_first
//  Description : Parallel-to-serial transmitter for operand pairs. Accepts
//                two WIDTH-bit operands over valid/ready and emits them one
//                bit per cycle, MSB first, on two lock-step lanes with
//                first/last word-framing strobes.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                in_valid   - operand pair offered
//                in_ready   - pair can be accepted this cycle
//                in_a/in_b  - parallel operands
//                out_valid  - serial lanes carry a live bit
//                out_a/out_b- serial bits, MSB first
//                out_first  - current bit is the MSB of a word
//                out_last   - current bit is the LSB of a word
//  Build macro : SERIALIZER_PRELOAD_EN - when defined, a new pair can be
//                accepted on the last-bit cycle so words stream with no
//                bubble. When undefined, at least one idle cycle separates
//                consecutive words.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_operand_serializer_msb_first
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);

  localparam int              CNT_W   = ser_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  ser_state_e       state_q;
  ser_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             lane_load;
  logic             lane_shift;
  logic             msb_a;
  logic             msb_b;
  logic             accept;

  // --------------------------------------------------------------------------
  // Ready decode: depends on state and counter only, never on in_valid.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
`ifdef SERIALIZER_PRELOAD_EN
        // Last-bit cycle doubles as a load slot for the next word.
        in_ready = (cnt_q == '0);
`else
        in_ready = 1'b0;
`endif
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Next-state, counter and lane control.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_load  = 1'b0;
    lane_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          lane_load = 1'b1;
          cnt_d     = CNT_MAX;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (accept) begin
          // Only reachable on the last bit with preload enabled: the new
          // word replaces the old one and its MSB appears next cycle.
          lane_load = 1'b1;
          cnt_d     = CNT_MAX;
          state_d   = SHIFT;
        end else if (cnt_q == '0) begin
          // Counter stops at zero; the lanes still shift (zero fill) so
          // they are empty while idle.
          lane_shift = 1'b1;
          state_d    = IDLE;
        end else begin
          lane_shift = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Operand lanes.
  // --------------------------------------------------------------------------
  shift_reg_msb #(
    .WIDTH     (WIDTH)
  ) u_lane_a (
    .clk       (clk),
    .rst       (rst),
    .load      (lane_load),
    .shift     (lane_shift),
    .load_data (in_a),
    .msb       (msb_a)
  );

  shift_reg_msb #(
    .WIDTH     (WIDTH)
  ) u_lane_b (
    .clk       (clk),
    .rst       (rst),
    .load      (lane_load),
    .shift     (lane_shift),
    .load_data (in_b),
    .msb       (msb_b)
  );

  // --------------------------------------------------------------------------
  // Output decode, purely from registered state. Lanes are forced low outside
  // SHIFT so the comparator never sees stale bits.
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_a     = 1'b0;
    out_b     = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    if (state_q == SHIFT) begin
      out_valid = 1'b1;
      out_a     = msb_a;
      out_b     = msb_b;
      out_first = (cnt_q == CNT_MAX);
      out_last  = (cnt_q == '0);
    end
  end

endmodule : serial_operand_serializer_msb_first
`default_nettype wire

// File: tb/tb_serial_operand_serializer_msb_first.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_operand_serializer_msb_first
//  Description : Self-checking bench for the MSB-first operand serializer.
//                A word-level reference model (accepted words indexed by bit
//                position) predicts in_ready and every output each cycle.
//                A second WIDTH=2 instance covers the narrowest legal width.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_operand_serializer_msb_first;

  localparam int W = 8;
`ifdef SERIALIZER_PRELOAD_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid, out_a, out_b, out_first, out_last;

  logic         v2, r2, ov2, oa2, ob2, of2, ol2;
  logic [1:0]   a2, b2;

  always #5 clk = ~clk;

  serial_operand_serializer_msb_first #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_first (out_first),
    .out_last  (out_last)
  );

  serial_operand_serializer_msb_first #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v2),
    .in_ready  (r2),
    .in_a      (a2),
    .in_b      (b2),
    .out_valid (ov2),
    .out_a     (oa2),
    .out_b     (ob2),
    .out_first (of2),
    .out_last  (ol2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the word being sent and the index of the bit on the wire.
  bit           m_busy;
  int           m_idx;
  logic [W-1:0] m_a, m_b;
  int           acc_cnt = 0;
  int           cyc = 0;
  logic [W-1:0] col_a, col_b;
  int           first_times[$];
  int           low_times[$];

  function automatic bit model_ready();
    return !m_busy || (PRE && m_idx == 0);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_idx  = 0;
    m_a    = '0;
    m_b    = '0;
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit           acc;
    logic [W-1:0] sa, sb;
    chk("in_ready", in_ready, model_ready());
    acc = in_valid && model_ready();
    sa  = in_a;
    sb  = in_b;
    @(posedge clk);
    cyc++;
    if (acc) begin
      m_a = sa; m_b = sb; m_idx = W - 1; m_busy = 1'b1; acc_cnt++;
    end else if (m_busy) begin
      if (m_idx == 0) m_busy = 1'b0;
      else m_idx--;
    end
    #1;
    chk("out_valid", out_valid, m_busy);
    chk("out_a",     out_a,     m_busy ? m_a[m_idx] : 1'b0);
    chk("out_b",     out_b,     m_busy ? m_b[m_idx] : 1'b0);
    chk("out_first", out_first, m_busy && m_idx == W - 1);
    chk("out_last",  out_last,  m_busy && m_idx == 0);
    if (out_valid === 1'b1) begin
      col_a = {col_a[W-2:0], out_a};
      col_b = {col_b[W-2:0], out_b};
    end else begin
      low_times.push_back(cyc);
    end
    if (out_first === 1'b1) first_times.push_back(cyc);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = acc_cnt;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 20 && acc_cnt == s; i++) cycle();
    in_valid = 1'b0;
    chk("send_accept", acc_cnt - s, 1);
  endtask

  initial begin
    int s, t1, t2, lows;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    v2 = 1'b0; a2 = '0; b2 = '0;
    col_a = '0; col_b = '0;
    model_reset();
    @(negedge clk); @(negedge clk);

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;
    cycle();

    // WIDTH=2: first and last on consecutive cycles
    v2 = 1'b1; a2 = 2'b10; b2 = 2'b01;
    @(posedge clk); #1;
    v2 = 1'b0;
    chk("w2_b1", {ov2, oa2, ob2, of2, ol2}, 5'b11010);
    chk("w2_ready_busy", r2, PRE ? 1'b0 : 1'b0);
    @(posedge clk); #1;
    chk("w2_b2", {ov2, oa2, ob2, of2, ol2}, 5'b10101);
    @(posedge clk); #1;
    chk("w2_idle", {ov2, oa2, ob2, of2, ol2}, 5'b00000);
    @(negedge clk);

    // Single word A5 / 3C
    col_a = '0; col_b = '0; first_times.delete();
    send(8'hA5, 8'h3C);
    drain(7);
    chk("single_a", col_a, 8'hA5);
    chk("single_b", col_b, 8'h3C);
    chk("single_nfirst", first_times.size(), 1);
    drain(2);

    // Back-to-back with in_valid held
    first_times.delete(); low_times.delete();
    s = acc_cnt;
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h00;
    for (int i = 0; i < 40 && acc_cnt < s + 2; i++) begin
      if (acc_cnt == s + 1) begin in_a = 8'h01; in_b = 8'h02; end
      cycle();
    end
    in_valid = 1'b0;
    drain(10);
    chk("b2b_nfirst", first_times.size(), 2);
    t1 = (first_times.size() > 0) ? first_times[0] : 0;
    t2 = (first_times.size() > 1) ? first_times[1] : 0;
    lows = 0;
    foreach (low_times[i]) if (low_times[i] > t1 && low_times[i] < t2) lows++;
    chk("b2b_gap", t2 - t1, PRE ? W : W + 1);
    chk("b2b_lows", lows, PRE ? 0 : 1);

    // Offer while busy: new data presented mid-word
    col_a = '0; col_b = '0;
    send(8'h5A, 8'hC3);
    drain(2);
    in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
    drain(5);
    chk("busy_a", col_a, 8'h5A);
    chk("busy_b", col_b, 8'hC3);
    col_a = '0; col_b = '0;
    send(8'h11, 8'h22);
    drain(7);
    chk("busy_next_a", col_a, 8'h11);
    chk("busy_next_b", col_b, 8'h22);
    drain(2);

    // Reset at bit 3 of F0/0F
    send(8'hF0, 8'h0F);
    drain(2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_outs", {out_valid, out_a, out_b, out_first, out_last}, 5'b0);
    chk("mid_rst_ready", in_ready, 1);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    cycle();
    col_a = '0; col_b = '0; first_times.delete();
    send(8'h12, 8'h34);
    drain(7);
    chk("post_rst_a", col_a, 8'h12);
    chk("post_rst_b", col_b, 8'h34);
    chk("post_rst_first", first_times.size(), 1);
    drain(2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      end
      s = acc_cnt;
      cycle();
      if (acc_cnt != s) begin
        if ($urandom_range(0, 1) == 0) begin
          in_valid = 1'b0;
        end else begin
          in_a = W'($urandom); in_b = W'($urandom);
        end
      end
    end
    in_valid = 1'b0;
    drain(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_operand_serializer_msb_first
`default_nettype wire
